load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store unit between the core's execute stage and data_memory.
//  Accepts one byte-addressed RV32I load/store request via valid/ready and converts it to word-indexed data_memory accesses.
//  Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
//  Misaligned, illegal-funct3 and out-of-range requests are flagged and never write memory.
// PARAMETERS
//  DATA_MEMORY_DEPTH  256  words in attached data_memory; valid word index 0..DEPTH-1
// PORTS
//  clk         in   1   single clock, all state on posedge
//  rst_n       in   1   synchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   LSU can accept (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (size/sign)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   one-cycle pulse, request complete
//  resp_rdata  out  32  extended load data (0 for stores/errors)
//  resp_err    out  1   misaligned/illegal/out-of-range, valid with resp_valid
//  mem_we      out  1   to data_memory WE
//  mem_a       out  32  to data_memory A: word index {2'b0, addr_q[31:2]}
//  mem_wd      out  32  to data_memory WD
//  mem_rd      in   32  from data_memory RD (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid/resp_err/mem_we=0; resp_rdata=0; latched request regs=0.
//  mem_we = (state==WRITE) & rst_n -> no memory write in any cycle rst_n is low.
//  Handshake: accept when req_valid & req_ready. Latch we/funct3/addr/wdata. Inputs ignored until next IDLE.
//  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only). Other codes, and 100/101 with we=1, are illegal.
//  Error check at accept:
//   - misaligned: H with addr[0]!=0; W with addr[1:0]!=0
//   - out of range: addr[31:2] >= DEPTH
//   - any error -> state ERR
//  FSM:
//   IDLE  -> ERR on error; READ on load or SB/SH; WRITE on SW
//   READ  : capture mem_rd into rd_q; load -> RESP, sub-word store -> WRITE
//   WRITE : mem_we=1
//           SW: mem_wd = wdata_q
//           SB: mem_wd = rd_q with byte lane addr_q[1:0] replaced by wdata_q[7:0]
//           SH: mem_wd = rd_q with half addr_q[1] replaced by wdata_q[15:0]
//           -> RESP
//   RESP  : resp_valid=1, resp_err=0 -> IDLE
//   ERR   : resp_valid=1, resp_err=1, resp_rdata=0 -> IDLE
//  Load extract from rd_q:
//   - lane = addr_q[1:0] (byte), addr_q[1] (half)
//   - B/H sign-extend; BU/HU zero-extend; W passthrough
//   - stores return 0
//  Latency from accept edge T:
//   error: resp at T+1
//   LW/LB/LH: resp at T+2
//   SW: resp at T+2
//   SB/SH: resp at T+3
//  Back-to-back: earliest next accept is the cycle after RESP/ERR; req_ready=0 during RESP/ERR.
//  resp_rdata/resp_err hold their last values outside resp_valid; only valid while resp_valid=1.
//  Reset mid-operation: FSM returns to IDLE at next edge, pending response is dropped, no partial write.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU); lsu_state_t enum {IDLE,READ,WRITE,RESP,ERR}.
//  Sub-module lsu_data_align (combinational): store lane merge (rd_q, wdata_q, funct3, addr[1:0]) -> mem_wd.
//  lsu_data_align also does load extract/extend -> resp_rdata next value.
//  Top: FSM, request latch, error decode, mem port drive.
// TESTING (bench uses real data_memory, DEPTH=256)
//  1 SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> mem word[4]=0xDEADBEEF, rdata=0xDEADBEEF, SW resp at T+2.
//  2 word[4]=0xDEADBEEF, SB 0x13 data=0x55 -> word[4]=0x55ADBEEF. Then LB 0x13 -> 0x00000055; LBU 0x12 -> 0x000000AD; LB 0x12 -> 0xFFFFFFAD.
//  3 SH 0x16 data=0x8001 -> word[5][31:16]=0x8001, low half unchanged. Then LH 0x16 -> 0xFFFF8001; LHU 0x16 -> 0x00008001.
//  4 LW 0x11, SH 0x13, funct3=011, SBU(we=1,f3=100), SW 0x400 -> each: resp_err=1 at T+1, no mem_we pulse.
//  5 req_valid held high for 3 back-to-back SW -> exactly one accept per RESP, req_ready low in READ/WRITE/RESP.
//  6 rst_n low during WRITE of SB 0x20 -> mem_we=0, word[8] unchanged, next cycle IDLE, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I load/store funct3 codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: merges sub-word store data into the read word and
// extracts/extends load data from a memory word.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_q,
    input  logic [31:0] i_wdata_q,
    input  logic [31:0] i_ld_src,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_we,
    output logic [31:0] o_mem_wd,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_ld_src[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_ld_src[31:16] : i_ld_src[15:0];

        o_ld_data = 32'h0;
        if (!i_we) begin
            unique case (i_funct3)
                F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
                F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
                F3_W:    o_ld_data = i_ld_src;
                F3_BU:   o_ld_data = {24'h0, w_byte};
                F3_HU:   o_ld_data = {16'h0, w_half};
                default: o_ld_data = 32'h0;
            endcase
        end

        o_mem_wd = i_wdata_q;
        unique case (i_funct3)
            F3_B: begin
                o_mem_wd = i_rd_q;
                o_mem_wd[{i_addr_lo, 3'b000} +: 8] = i_wdata_q[7:0];
            end
            F3_H: begin
                o_mem_wd = i_rd_q;
                if (i_addr_lo[1]) o_mem_wd[31:16] = i_wdata_q[15:0];
                else              o_mem_wd[15:0]  = i_wdata_q[15:0];
            end
            default: o_mem_wd = i_wdata_q;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit driving a word-indexed, combinational-read data memory.
// Sub-word stores read-modify-write; bad requests answer with resp_err and never write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_MEMORY_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  r_state, w_next;
    logic        r_we, r_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rd, r_rdata;
    logic        w_accept, w_illegal, w_misalign, w_oor, w_req_err;
    logic [31:0] w_ld_data, w_mem_wd;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;

    always_comb begin
        w_illegal = 1'b0;
        unique case (req_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = req_we;
            default:          w_illegal = 1'b1;
        endcase
        w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                   || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        w_oor      = ({2'b00, req_addr[31:2]} >= 32'(DATA_MEMORY_DEPTH));
        w_req_err  = w_illegal | w_misalign | w_oor;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err)                            w_next = ERR;
                    else if (req_we && (req_funct3 == F3_W)) w_next = WRITE;
                    else                                      w_next = READ;
                end
            end
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Response data is registered as the FSM enters RESP/ERR so it holds afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rd    <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == READ) r_rd <= mem_rd;
            if (w_next == RESP) begin
                r_err   <= 1'b0;
                r_rdata <= (r_state == READ) ? w_ld_data : 32'h0;
            end
            if (w_next == ERR) begin
                r_err   <= 1'b1;
                r_rdata <= 32'h0;
            end
        end
    end

    lsu_data_align u_align (
        .i_rd_q    (r_rd),
        .i_wdata_q (r_wdata),
        .i_ld_src  (mem_rd),
        .i_funct3  (r_f3),
        .i_addr_lo (r_addr[1:0]),
        .i_we      (r_we),
        .o_mem_wd  (w_mem_wd),
        .o_ld_data (w_ld_data)
    );

    assign mem_we     = (r_state == WRITE) & rst_n;
    assign mem_a      = {2'b00, r_addr[31:2]};
    assign mem_wd     = w_mem_wd;
    assign resp_valid = (r_state == RESP) || (r_state == ERR);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word combinational-read memory model.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    load_store_unit #(.DATA_MEMORY_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we && (mem_a < 32'd256)) mem[mem_a[7:0]] <= mem_wd;
    assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:0]] : 32'h0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          writes;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                                input logic err, input int writes);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.rdata = rdata; v.err = err; v.writes = writes;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, output int lat, output logic [31:0] rd,
                          output logic er, output int wr);
        int n;
        lat = 0; rd = 32'h0; er = 1'b0; wr = 0; n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) wr++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int lat, wr, resp_cnt;
        logic [31:0] rd;
        logic er;
        vec_t v;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        rst_n = 1'b1;

        vecs.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 2, 32'h0,        0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        2, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 3'b000, 32'h13,  32'h00000055, 3, 32'h0,        0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        2, 32'h55ADBEEF, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h13,  32'h0,        2, 32'h00000055, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h12,  32'h0,        2, 32'h000000AD, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h12,  32'h0,        2, 32'hFFFFFFAD, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'h14,  32'h12345678, 2, 32'h0,        0, 1));
        vecs.push_back(mk(1, 3'b001, 32'h16,  32'h00008001, 3, 32'h0,        0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h14,  32'h0,        2, 32'h80015678, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h16,  32'h0,        2, 32'hFFFF8001, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h16,  32'h0,        2, 32'h00008001, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h14,  32'h0,        2, 32'h00005678, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h11,  32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(1, 3'b001, 32'h13,  32'h0000FFFF, 1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 3'b011, 32'h10,  32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(1, 3'b100, 32'h10,  32'h000000AA, 1, 32'h0,        1, 0));
        vecs.push_back(mk(1, 3'b010, 32'h400, 32'h11111111, 1, 32'h0,        1, 0));
        vecs.push_back(mk(1, 3'b010, 32'h3FC, 32'hA5A50F0F, 2, 32'h0,        0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h3FC, 32'h0,        2, 32'hA5A50F0F, 0, 0));

        foreach (vecs[i]) begin
            do_req(vecs[i], lat, rd, er, wr);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].err});
            chk($sformatf("v%0d_mem_we_pulses", i), 32'(wr), 32'(vecs[i].writes));
        end
        chk("mem_word4", mem[4], 32'h55ADBEEF);
        chk("mem_word5", mem[5], 32'h80015678);
        chk("mem_word255", mem[255], 32'hA5A50F0F);

        @(negedge clk);
        chk("hold_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("hold_rdata", resp_rdata, 32'hA5A50F0F);

        // Back-to-back stores with req_valid held high: IDLE/WRITE/RESP rhythm.
        resp_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                req_we = 1'b1; req_funct3 = 3'b010;
                req_addr = 32'h40; req_wdata = 32'h11110000; req_valid = 1'b1;
            end
            chk($sformatf("b2b_ready_c%0d", c), {31'h0, req_ready}, (c % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("b2b_resp_c%0d", c), {31'h0, resp_valid}, (c % 3 == 2) ? 32'h1 : 32'h0);
            if (resp_valid) resp_cnt++;
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_addr = req_addr + 32'd4;
                req_wdata = req_wdata + 32'd1;
                if (c == 6) req_valid = 1'b0;
            end
        end
        chk("b2b_resp_count", 32'(resp_cnt), 32'd3);
        chk("b2b_word16", mem[16], 32'h11110000);
        chk("b2b_word17", mem[17], 32'h11110001);
        chk("b2b_word18", mem[18], 32'h11110002);

        // Reset asserted while an SB sits in WRITE.
        v = mk(1, 3'b010, 32'h20, 32'hCAFEF00D, 2, 32'h0, 0, 1);
        do_req(v, lat, rd, er, wr);
        chk("rst_prep_latency", 32'(lat), 32'd2);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_write_active", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_we_gated", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        chk("rst_mid_idle", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("rst_mid_word8", mem[8], 32'hCAFEF00D);
        rst_n = 1'b1;
        resp_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        chk("rst_mid_dropped_resp", 32'(resp_cnt), 32'd0);
        v = mk(0, 3'b010, 32'h20, 32'h0, 2, 32'hCAFEF00D, 0, 0);
        do_req(v, lat, rd, er, wr);
        chk("rst_post_lw_rdata", rd, 32'hCAFEF00D);
        chk("rst_post_lw_latency", 32'(lat), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
